// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and default sizes for the shared-register arbiter.
// No ports: arb_state_t plus default NREQ / WIDTH / MAX_LOCK.
package shared_reg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_MAX_LOCK = 8;

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// req/lock/data in from requesters; gnt/owner/Q/Q_valid back.
interface shared_reg_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       lock;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic [IW-1:0]         owner;
   logic [WIDTH-1:0]      Q;
   logic                  Q_valid;

   modport master (
      output req, lock, data,
      input  gnt, owner, Q, Q_valid
   );

   modport slave (
      input  req, lock, data,
      output gnt, owner, Q, Q_valid
   );
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin pick: first req at or after ptr.
// in: req, ptr   out: win (one-hot), idx, any.
module rr_priority_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   idx,
   output logic            any
);
   logic [IW:0]   s;
   logic [IW-1:0] j;

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      win = '0;
      idx = '0;
      any = 1'b0;
      s   = '0;
      j   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         s = {1'b0, ptr} + (IW+1)'(k);
         if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
         j = s[IW-1:0];
         if (req[j]) begin
            any = 1'b1;
            idx = j;
         end
      end
      win[idx] = any;
   end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register Q.
// Clock/Resetn (sync, active-low) plus bus: req/lock/data -> gnt/owner/Q/Q_valid.
module shared_reg_arbiter
   import shared_reg_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_LOCK = DEF_MAX_LOCK
) (
   input logic                Clock,
   input logic                Resetn,
   shared_reg_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] CNT_LIM = CW'(MAX_LOCK - 1);

   arb_state_t       state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q_valid_q, q_valid_d;

   logic            active, hit, cont;
   logic [IW-1:0]   ptr_inc, pick_ptr;
   logic [NREQ-1:0] pick_win;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

   // Grant continuation, and the priority used if it ends now.
   always_comb begin
      active  = (state_q != IDLE);
      hit     = active && bus.req[owner_q];
      ptr_inc = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
      cont    = 1'b0;
      unique case (state_q)
         GRANT:   cont = hit && bus.lock[owner_q] && (MAX_LOCK > 1);
         LOCKED:  cont = hit && bus.lock[owner_q]
                         && (lock_cnt_q < CNT_LIM);
         default: cont = 1'b0;
      endcase
      pick_ptr = (active && !cont) ? ptr_inc : ptr_q;
   end

   rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req (bus.req),
      .ptr (pick_ptr),
      .win (pick_win),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      lock_cnt_d = lock_cnt_q;
      q_d        = q_q;
      q_valid_d  = 1'b0;
      if (hit) begin
         q_d       = bus.data[int'(owner_q)*WIDTH +: WIDTH];
         q_valid_d = 1'b1;
      end
      if (cont) begin
         state_d    = LOCKED;
         lock_cnt_d = lock_cnt_q + CW'(1);
      end else begin
         lock_cnt_d = '0;
         if (active) ptr_d = ptr_inc;
         // Back-to-back: next winner chosen with the updated pointer.
         if (pick_any) begin
            state_d = GRANT;
            gnt_d   = pick_win;
            owner_d = pick_idx;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         ptr_q      <= '0;
         lock_cnt_q <= '0;
         q_q        <= '0;
         q_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         lock_cnt_q <= lock_cnt_d;
         q_q        <= q_d;
         q_valid_q  <= q_valid_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.owner   = owner_q;
   assign bus.Q       = q_q;
   assign bus.Q_valid = q_valid_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NREQ=4 and NREQ=3).
// Table of per-cycle vectors plus hand sequences for lock/reset.
module tb_shared_reg_arbiter;

   logic Clock = 1'b0;
   logic Resetn = 1'b0;
   always #5 Clock = ~Clock;

   shared_reg_arbiter_if #(.NREQ(4), .WIDTH(8)) u_if ();
   shared_reg_arbiter_if #(.NREQ(3), .WIDTH(8)) u_if3 ();

   shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAX_LOCK(8)) u_dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (u_if.slave)
   );

   shared_reg_arbiter #(.NREQ(3), .WIDTH(8), .MAX_LOCK(8)) u_dut3 (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (u_if3.slave)
   );

   typedef struct {
      logic        rn;
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [31:0] data;
      logic [3:0]  gnt;
      logic [1:0]  owner;
      logic [7:0]  q;
      logic        qv;
   } vec_t;

   localparam logic [31:0] DA = 32'h13_A5_11_10;
   localparam logic [31:0] DB = 32'h13_12_11_10;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t tbl[19];

   function automatic vec_t mk(logic rn, logic [3:0] rq, logic [31:0] d,
                               logic [3:0] g, logic [1:0] o,
                               logic [7:0] q, logic qv);
      vec_t v;
      v.rn = rn; v.req = rq; v.lock = 4'b0000; v.data = d;
      v.gnt = g; v.owner = o; v.q = q; v.qv = qv;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      u_if.req = '0;
      u_if.lock = '0;
      tick();
      Resetn = 1'b1;
   endtask

   initial begin
      // Test 1: reset, single request from 2.
      tbl[0]  = mk(0, 4'b0000, DA, 4'b0000, 0, 8'h00, 0);
      tbl[1]  = mk(0, 4'b0000, DA, 4'b0000, 0, 8'h00, 0);
      tbl[2]  = mk(0, 4'b0000, DA, 4'b0000, 0, 8'h00, 0);
      tbl[3]  = mk(1, 4'b0100, DA, 4'b0100, 2, 8'h00, 0);
      tbl[4]  = mk(1, 4'b0100, DA, 4'b0100, 2, 8'hA5, 1);
      tbl[5]  = mk(1, 4'b0000, DA, 4'b0000, 2, 8'hA5, 0);
      tbl[6]  = mk(1, 4'b0000, DA, 4'b0000, 2, 8'hA5, 0);
      // Test 2: all requesting, rotation.
      tbl[7]  = mk(0, 4'b0000, DB, 4'b0000, 0, 8'h00, 0);
      tbl[8]  = mk(1, 4'b1111, DB, 4'b0001, 0, 8'h00, 0);
      tbl[9]  = mk(1, 4'b1111, DB, 4'b0010, 1, 8'h10, 1);
      tbl[10] = mk(1, 4'b1111, DB, 4'b0100, 2, 8'h11, 1);
      tbl[11] = mk(1, 4'b1111, DB, 4'b1000, 3, 8'h12, 1);
      tbl[12] = mk(1, 4'b1111, DB, 4'b0001, 0, 8'h13, 1);
      tbl[13] = mk(1, 4'b1111, DB, 4'b0010, 1, 8'h10, 1);
      // Test 4: owner 0 aborts, 1 takes over.
      tbl[14] = mk(0, 4'b0000, DB, 4'b0000, 0, 8'h00, 0);
      tbl[15] = mk(1, 4'b0011, DB, 4'b0001, 0, 8'h00, 0);
      tbl[16] = mk(1, 4'b0010, DB, 4'b0010, 1, 8'h00, 0);
      tbl[17] = mk(1, 4'b0010, DB, 4'b0010, 1, 8'h11, 1);
      tbl[18] = mk(1, 4'b0000, DB, 4'b0000, 1, 8'h11, 0);

      u_if.req = '0; u_if.lock = '0; u_if.data = '0;
      u_if3.req = '0; u_if3.lock = '0;
      u_if3.data = 24'h22_21_20;
      #1;

      foreach (tbl[i]) begin
         Resetn     = tbl[i].rn;
         u_if.req   = tbl[i].req;
         u_if.lock  = tbl[i].lock;
         u_if.data  = tbl[i].data;
         tick();
         chk($sformatf("v%0d gnt", i), 32'(u_if.gnt), 32'(tbl[i].gnt));
         chk($sformatf("v%0d owner", i), 32'(u_if.owner), 32'(tbl[i].owner));
         chk($sformatf("v%0d Q", i), 32'(u_if.Q), 32'(tbl[i].q));
         chk($sformatf("v%0d Q_valid", i), 32'(u_if.Q_valid), 32'(tbl[i].qv));
      end

      // Test 3: locked burst from 1 bounded to 8 cycles.
      do_reset();
      u_if.data = DB;
      u_if.req  = 4'b1010;
      u_if.lock = 4'b0010;
      for (int c = 0; c < 8; c++) begin
         tick();
         chk($sformatf("lock c%0d gnt", c), 32'(u_if.gnt), 32'h2);
         if (c > 0) chk($sformatf("lock c%0d Q_valid", c),
                        32'(u_if.Q_valid), 32'h1);
      end
      tick();
      chk("lock rel gnt", 32'(u_if.gnt), 32'h8);
      chk("lock last Q", 32'(u_if.Q), 32'h11);
      chk("lock last Q_valid", 32'(u_if.Q_valid), 32'h1);
      tick();
      chk("lock back gnt", 32'(u_if.gnt), 32'h2);
      chk("lock back Q", 32'(u_if.Q), 32'h13);

      // Test 5: reset mid-burst with owner 2.
      do_reset();
      u_if.data = DA;
      u_if.req  = 4'b0100;
      u_if.lock = 4'b0100;
      tick();
      tick();
      tick();
      chk("burst gnt", 32'(u_if.gnt), 32'h4);
      chk("burst Q", 32'(u_if.Q), 32'hA5);
      Resetn = 1'b0;
      u_if.data = DB;
      tick();
      chk("mid rst gnt", 32'(u_if.gnt), 32'h0);
      chk("mid rst Q", 32'(u_if.Q), 32'h0);
      chk("mid rst Q_valid", 32'(u_if.Q_valid), 32'h0);
      chk("mid rst owner", 32'(u_if.owner), 32'h0);
      Resetn = 1'b1;
      u_if.req  = 4'b1111;
      u_if.lock = 4'b0000;
      tick();
      chk("post rst gnt", 32'(u_if.gnt), 32'h1);
      chk("post rst Q", 32'(u_if.Q), 32'h0);

      // Test 6: NREQ=3 wrap, ptr=2 after serving 1.
      do_reset();
      u_if3.req = 3'b010;
      tick();
      chk("n3 first gnt", 32'(u_if3.gnt), 32'h2);
      u_if3.req = 3'b101;
      tick();
      chk("n3 gnt2", 32'(u_if3.gnt), 32'h4);
      chk("n3 owner2", 32'(u_if3.owner), 32'h2);
      tick();
      chk("n3 gnt0", 32'(u_if3.gnt), 32'h1);
      chk("n3 owner0", 32'(u_if3.owner), 32'h0);
      chk("n3 Q", 32'(u_if3.Q), 32'h22);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("n3 c%0d owner<3", c),
             32'(u_if3.owner < 2'd3), 32'h1);
         chk($sformatf("n3 c%0d gnt", c), 32'(u_if3.gnt),
             (c % 2 == 0) ? 32'h4 : 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
